// File: rtl/decoder_2to4_pulse_pkg.sv
// Shared types and helpers for the 2-to-4 pulse decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package decoder_pkg;

  localparam int CODE_W = 2;
  localparam int LINES  = 4;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Map a binary select code onto its single active line.
  function automatic logic [LINES-1:0] onehot(input logic [CODE_W-1:0] code);
    logic [LINES-1:0] v;
    v       = '0;
    v[code] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/decoder_2to4_pulse_hold_counter.sv
// Loadable down-counter that parks at zero; times the hold and gap phases.
// Latency: load/dec/clear take effect on the next clock; zero is from the register.
// Backpressure: none; dec at zero is ignored so the count never wraps.
module hold_counter
  import decoder_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  input  logic             clear,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear beats load beats decrement; saturate at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/decoder_2to4_pulse.sv
// Accepts a 2-bit code, drives its one-hot line for HOLD_CYCLES, idles GAP_CYCLES, pulses done.
// Latency: out valid the cycle after accept; done HOLD_CYCLES cycles after that.
// Backpressure: in_ready low from accept until the gap ends; abort returns to ready next cycle.
module decoder_2to4_pulse
  import decoder_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [CODE_W-1:0] in_code,
  output logic              in_ready,
  input  logic              abort,
  output logic [LINES-1:0]  out,
  output logic              out_active,
  output logic              done
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;
  localparam logic             HAS_GAP   = (GAP_CYCLES > 0);

  state_t           state_q, state_d;
  logic [LINES-1:0] out_q, out_d;
  logic             out_active_q, out_active_d;
  logic             done_q, done_d;
  logic             in_ready_q, in_ready_d;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic             cnt_clear;
  logic             cnt_zero;

  hold_counter u_hold_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .clear    (cnt_clear),
    .zero     (cnt_zero)
  );

  // Next state, counter control and registered-output values.
  always_comb begin
    state_d      = state_q;
    out_d        = out_q;
    done_d       = 1'b0;
    in_ready_d   = in_ready_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    cnt_clear    = 1'b0;

    case (state_q)
      IDLE: begin
        out_d      = '0;
        in_ready_d = 1'b1;
        // abort is meaningless here, so an accept always wins.
        if (in_valid && in_ready_q) begin
          state_d      = HOLD;
          out_d        = onehot(in_code);
          in_ready_d   = 1'b0;
          cnt_load     = 1'b1;
          cnt_load_val = HOLD_LOAD;
        end
      end

      HOLD: begin
        in_ready_d = 1'b0;
        if (abort) begin
          state_d    = IDLE;
          out_d      = '0;
          in_ready_d = 1'b1;
          cnt_clear  = 1'b1;
        end else if (cnt_zero) begin
          out_d  = '0;
          done_d = 1'b1;
          if (HAS_GAP) begin
            state_d      = GAP;
            cnt_load     = 1'b1;
            cnt_load_val = GAP_LOAD;
          end else begin
            // No gap: ready rises alongside done so back-to-back accepts work.
            state_d    = IDLE;
            in_ready_d = 1'b1;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end

      GAP: begin
        out_d      = '0;
        in_ready_d = 1'b0;
        if (abort) begin
          state_d    = IDLE;
          in_ready_d = 1'b1;
          cnt_clear  = 1'b1;
        end else if (cnt_zero) begin
          state_d    = IDLE;
          in_ready_d = 1'b1;
        end else begin
          cnt_dec = 1'b1;
        end
      end

      default: begin
        state_d    = IDLE;
        out_d      = '0;
        in_ready_d = 1'b1;
        cnt_clear  = 1'b1;
      end
    endcase

    out_active_d = |out_d;
  end

  // State and output registers; reset drives everything idle immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      out_q        <= '0;
      out_active_q <= 1'b0;
      done_q       <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      out_q        <= out_d;
      out_active_q <= out_active_d;
      done_q       <= done_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign out        = out_q;
  assign out_active = out_active_q;
  assign done       = done_q;
  assign in_ready   = in_ready_q;

endmodule

// File: doc/decoder_2to4_pulse.md
# decoder_2to4_pulse

Sequential 2-to-4 decoder: the decode-side counterpart of the team's 4-to-2 one-hot encoder. It accepts a 2-bit code over a valid/ready handshake and drives the matching one-hot line for a fixed number of cycles. It then enforces an idle gap and pulses `done`. It sits between control logic that produces encoded select values and downstream one-hot enables such as strobes, chip selects and mux selects.

## Interface
Parameters:
- `HOLD_CYCLES`, default 4: cycles the one-hot output is held. Legal range 1..255.
- `GAP_CYCLES`, default 1: all-zero cycles enforced after the hold, before the next accept. Legal range 0..255.

Ports (reset is asynchronous, active-low; one clock):
- `clk`  in  1  block clock, rising-edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  code presented.
- `in_code`  in  2  code to decode.
- `in_ready`  out  1  block can accept a code.
- `abort`  in  1  cancel the current hold or gap.
- `out`  out  4  one-hot decoded lines; 4'b0000 when not holding.
- `out_active`  out  1  high while `out` is non-zero.
- `done`  out  1  one-cycle pulse when a hold completes normally.

## Operation
- States: IDLE, HOLD, GAP. All outputs are registered.
- IDLE:
  - `in_ready`=1 and `out`=0000.
  - On `in_valid & in_ready`, the next state is HOLD, `out` = 1 << `in_code`, and the counter loads HOLD_CYCLES-1.
- HOLD:
  - `out` stays constant and `in_ready`=0.
  - The counter decrements each cycle.
  - When the counter is 0, the next state is GAP (counter loads GAP_CYCLES-1) if GAP_CYCLES>0, otherwise IDLE.
  - On that transition, `out` becomes 0000 and `done` is 1 for one cycle.
- GAP:
  - `out`=0000 and `in_ready`=0.
  - The counter decrements each cycle; at 0 the next state is IDLE.
- `abort` (sampled in HOLD or GAP):
  - The next state is IDLE with `out`=0000.
  - No `done` pulse is produced.
  - Counter is cleared.
  - `abort` in IDLE is ignored.
  - `abort` in IDLE with `in_valid` asserted in the same cycle: the accept still happens.
- `in_code` is captured only on an accept. Changes to `in_code` while not ready have no effect.
- `in_valid` held high continuously: one code is accepted each time IDLE is reached, using the code present in that cycle.
- `out` is always one-hot or zero; no other value is legal.
- `out_active` equals the OR of `out`.
- Counter is 8 bits and never wraps: it decrements from its load value to 0 only.

## Timing
- Reset values: `out`=0000, `out_active`=0, `done`=0, `in_ready`=1, state IDLE, counter 0.
- Reset asserted mid-HOLD or mid-GAP: outputs go to their reset values immediately (asynchronously), with no `done`.
- Accept at edge T:
  - `out` is valid from T+1 through T+HOLD_CYCLES.
  - `done` and `out`=0000 occur at T+HOLD_CYCLES+1.
  - `in_ready` is high again at T+HOLD_CYCLES+GAP_CYCLES+1.
- Throughput: one code per HOLD_CYCLES+GAP_CYCLES+1 cycles.
- With GAP_CYCLES=0, `done` and `in_ready` rise in the same cycle. An accept in that cycle is legal; it gives a single zero cycle between holds.
- `abort` sampled at edge A: `out`=0000 and `in_ready`=1 from A+1.

## Structure
- Shared package `decoder_pkg`:
  - `state_t` enum {IDLE, HOLD, GAP}.
  - `CODE_W`=2 and `LINES`=4.
  - `onehot(code)` function.
- Sub-module `hold_counter`:
  - 8-bit loadable down-counter with `load`, `load_val`, `dec` and `clear` inputs, and a `zero` flag.
  - Instantiated once.
- FSM and output registers live in the top module.

## Test plan
- Reset, then accept `in_code`=2 with HOLD=4, GAP=1:
  - `out`=0100 for 4 cycles.
  - `done` pulses in cycle 5 with `out`=0000.
  - `in_ready`=1 in cycle 6.
- Sweep codes 0,1,2,3 back-to-back with `in_valid` held high → `out` sequence 0001, 0010, 0100, 1000, each held 4 cycles and separated by exactly 1 zero cycle after `done`.
- HOLD=1, GAP=0, continuous `in_valid` with code 3 → `out` alternates 1000/0000 every cycle, and `done` pulses on each zero cycle.
- `abort` in the 2nd HOLD cycle of code 1 → `out`=0000 next cycle, no `done`, `in_ready`=1 next cycle.
- Deassert `rst_n` mid-HOLD (code 0) → `out`=0000 and `in_ready`=1 immediately. After release, a new accept of code 2 yields `out`=0100.
- Change `in_code` from 1 to 3 during HOLD → `out` stays 0010 for the full hold.
